ysyx_25060170_lsu: RTL and testbench

YSYX_25060170_LSU -- requirements
Module: ysyx_25060170_LSU

---
 rtl/ysyx_25060170_lsu_pkg.sv | 33 +++
 rtl/ysyx_25060170_lsu_align.sv | 48 ++++
 rtl/ysyx_25060170_lsu.sv | 131 +++++++++++++
 tb/tb_ysyx_25060170_lsu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060170_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_25060170_lsu_pkg
// Brief   : Shared types, size encodings and helpers for the load/store unit.
// Revision: 1.0
// ============================================================================
package ysyx_25060170_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int TIMEOUT_DEFAULT = 255;

    // Accesses that must be rejected without touching the bus.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25060170_lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_25060170_lsu_align
// Brief   : Byte-lane placement of store data/strobes and load extraction.
// Revision: 1.0
// ============================================================================
module ysyx_25060170_lsu_align
    import ysyx_25060170_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  lane_strb,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] load_shifted;

    assign lane_wdata   = store_data << {addr_lo, 3'b000};
    assign load_shifted = load_word >> {addr_lo, 3'b000};

    always_comb begin
        lane_strb = 4'b0000;
        case (size)
            SZ_B:    lane_strb = 4'b0001 << addr_lo;
            SZ_H:    lane_strb = 4'b0011 << addr_lo;
            SZ_W:    lane_strb = 4'b1111;
            default: lane_strb = 4'b0000;
        endcase
    end

    always_comb begin
        load_data = 32'h0;
        case (size)
            SZ_B:    load_data = load_unsigned ? {24'h0, load_shifted[7:0]}
                                               : {{24{load_shifted[7]}}, load_shifted[7:0]};
            SZ_H:    load_data = load_unsigned ? {16'h0, load_shifted[15:0]}
                                               : {{16{load_shifted[15]}}, load_shifted[15:0]};
            SZ_W:    load_data = load_shifted;
            default: load_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25060170_lsu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_25060170_lsu
// Brief   : Single-outstanding load/store unit between EXU/WBU and a simple bus.
// Revision: 1.0
// ============================================================================
module ysyx_25060170_lsu
    import ysyx_25060170_lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state;
    lsu_state_t       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             acc_wen;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [1:0]       acc_size;
    logic             acc_unsigned;
    logic             accept;
    logic             req_bad;
    logic             timed_out;
    logic [3:0]       lane_strb;
    logic [31:0]      load_data;

    assign accept    = (state == S_IDLE) && req_valid;
    assign req_bad   = is_bad_access(req_size, req_addr[1:0]);
    assign timed_out = (wait_cnt == CNT_LAST);

    ysyx_25060170_lsu_align u_align (
        .size          (acc_size),
        .addr_lo       (acc_addr[1:0]),
        .load_unsigned (acc_unsigned),
        .store_data    (acc_wdata),
        .load_word     (mem_rdata),
        .lane_strb     (lane_strb),
        .lane_wdata    (mem_wdata),
        .load_data     (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req_valid)                  state_next = req_bad ? S_RESP : S_REQ;
            S_REQ:  if (mem_ready)                  state_next = S_WAIT;
            S_WAIT: if (mem_rvalid || timed_out)    state_next = S_RESP;
            S_RESP: if (resp_ready)                 state_next = S_IDLE;
            default:                                state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        mem_valid  = (state == S_REQ);
        resp_valid = (state == S_RESP);
    end

    // rvalid wins over an expiring timeout in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt     <= '0;
            acc_wen      <= 1'b0;
            acc_addr     <= 32'h0;
            acc_wdata    <= 32'h0;
            acc_size     <= 2'b00;
            acc_unsigned <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
        end else if (accept) begin
            wait_cnt     <= '0;
            acc_wen      <= req_wen;
            acc_addr     <= req_addr;
            acc_wdata    <= req_wdata;
            acc_size     <= req_size;
            acc_unsigned <= req_unsigned;
            resp_rdata   <= 32'h0;
            resp_err     <= req_bad;
        end else if (state == S_WAIT) begin
            if (mem_rvalid) begin
                resp_err   <= mem_err;
                resp_rdata <= (mem_err || acc_wen) ? 32'h0 : load_data;
            end else if (timed_out) begin
                resp_err   <= 1'b1;
                resp_rdata <= 32'h0;
            end else begin
                wait_cnt   <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_wen   = acc_wen;
    assign mem_addr  = {acc_addr[31:2], 2'b00};
    assign mem_wstrb = acc_wen ? lane_strb : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_25060170_lsu
// Brief   : Scoreboard bench for the load/store unit with directed vectors.
// Revision: 1.0
// ============================================================================
module tb_ysyx_25060170_lsu;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_err = 1'b0;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    ysyx_25060170_lsu #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_err      (mem_err)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    // Bus monitor: every cycle mem_valid is high the request must match and stay put.
    always @(negedge clk) begin
        if (rst && mem_valid) begin
            if (bus_q.size() == 0) begin
                check("unexpected mem_valid", 32'(mem_valid), 32'd0);
            end else begin
                check("mem_wen", 32'(mem_wen), 32'(bus_q[0].wen));
                check("mem_addr", mem_addr, bus_q[0].addr);
                check("mem_wstrb", 32'(mem_wstrb), 32'(bus_q[0].strb));
                if (bus_q[0].wen) check("mem_wdata", mem_wdata, bus_q[0].wdata);
                if (mem_ready) void'(bus_q.pop_front());
            end
        end
    end

    // Response monitor: result must match and stay stable until accepted.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (resp_q.size() == 0) begin
                check("unexpected resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                check("resp_rdata", resp_rdata, resp_q[0].rdata);
                check("resp_err", 32'(resp_err), 32'(resp_q[0].err));
                if (resp_ready) void'(resp_q.pop_front());
            end
        end
    end

    // rv_dly < 0 means the bus never answers.
    task automatic access(input string name, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input int rdy_dly, input int rv_dly, input logic [31:0] rd,
                          input logic merr, input int resp_dly, input bit bus,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int c, rc, wc, pc, lat;
        bit in_wait, bus_hs, resp_hs, sent;
        c = 0; rc = 0; wc = 0; pc = 0; lat = -1;
        in_wait = 0; bus_hs = 0; resp_hs = 0; sent = 0;
        if (bus) bus_q.push_back('{wen, {addr[31:2], 2'b00}, exp_wdata, exp_strb});
        resp_q.push_back('{exp_rdata, exp_err});
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        forever begin
            c++;
            if (bus_hs) in_wait = 1;
            bus_hs = 0; mem_ready = 0; mem_rvalid = 0; mem_err = 0; resp_ready = 0;
            if (mem_valid) begin
                if (rc == rdy_dly) begin mem_ready = 1; bus_hs = 1; end
                rc++;
            end
            if (in_wait && !sent && rv_dly >= 0) begin
                if (wc == rv_dly) begin mem_rvalid = 1; mem_rdata = rd; mem_err = merr; sent = 1; end
                wc++;
            end
            if (resp_valid) begin
                if (lat < 0) lat = c;
                if (pc == resp_dly) begin resp_ready = 1; resp_hs = 1; end
                pc++;
            end
            @(posedge clk); #1;
            if (resp_hs || c >= 40) break;
        end
        mem_ready = 0; mem_rvalid = 0; mem_err = 0; resp_ready = 0;
        check({name, " completed"}, 32'(resp_hs), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset mem_valid", 32'(mem_valid), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        check("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        //      name   wen  addr          wdata         size   uns rdy rv  mem_rdata     err rsp bus exp_wdata     strb     exp_rdata     err lat
        access("SB",   1, 32'h80000003, 32'h000000AB, 2'b00, 0, 0, 0, 32'h0,        0, 0, 1, 32'hAB000000, 4'b1000, 32'h0,        0, 3);
        access("LH",   0, 32'h80000002, 32'h0,        2'b01, 0, 0, 0, 32'h80011234, 0, 0, 1, 32'h0,        4'b0000, 32'hFFFF8001, 0, 3);
        access("LHU",  0, 32'h80000002, 32'h0,        2'b01, 1, 0, 0, 32'h80011234, 0, 0, 1, 32'h0,        4'b0000, 32'h00008001, 0, 3);
        access("LWmis",0, 32'h80000002, 32'h0,        2'b10, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 1);
        // mem_ready low in cycles 0..4, high in cycle 5 -> resp_valid 7 cycles after accept
        access("LWslow",0,32'h80000010, 32'h0,        2'b10, 0, 4, 0, 32'hDEADBEEF, 0, 3, 1, 32'h0,        4'b0000, 32'hDEADBEEF, 0, 7);
        access("LWto", 0, 32'h80000020, 32'h0,        2'b10, 0, 0, -1,32'h0,        0, 0, 1, 32'h0,        4'b0000, 32'h0,        1, 6);
        access("LWerr",0, 32'h80000024, 32'h0,        2'b10, 0, 0, 1, 32'h12345678, 1, 0, 1, 32'h0,        4'b0000, 32'h0,        1, 4);
        access("LB",   0, 32'h80000001, 32'h0,        2'b00, 0, 1, 0, 32'h00008000, 0, 1, 1, 32'h0,        4'b0000, 32'hFFFFFF80, 0, 4);
        access("LBU",  0, 32'h80000001, 32'h0,        2'b00, 1, 0, 0, 32'h00008000, 0, 0, 1, 32'h0,        4'b0000, 32'h00000080, 0, 3);
        access("LB0",  0, 32'h80000000, 32'h0,        2'b00, 0, 0, 0, 32'hFFFFFF7F, 0, 0, 1, 32'h0,        4'b0000, 32'h0000007F, 0, 3);
        access("SH",   1, 32'h80000002, 32'h0000BEEF, 2'b01, 0, 0, 0, 32'h0,        0, 0, 1, 32'hBEEF0000, 4'b1100, 32'h0,        0, 3);
        access("SW",   1, 32'h80000004, 32'h11223344, 2'b10, 0, 0, 2, 32'h0,        0, 0, 1, 32'h11223344, 4'b1111, 32'h0,        0, 5);
        access("SZ11", 0, 32'h80000000, 32'h0,        2'b11, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 1);
        access("SHmis",1, 32'h80000001, 32'h00001234, 2'b01, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 1);

        // Reset while waiting for read data, then a stray rvalid.
        bus_q.push_back('{1'b0, 32'h80000040, 32'h0, 4'b0000});
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000040; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("abort req_ready", 32'(req_ready), 32'd1);
        check("abort resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stray resp_valid", 32'(resp_valid), 32'd0);
        check("stray req_ready", 32'(req_ready), 32'd1);
        check("stray resp_rdata", resp_rdata, 32'h0);

        access("after", 0, 32'h80000008, 32'h0, 2'b10, 0, 0, 0, 32'h0BADF00D, 0, 0, 1, 32'h0, 4'b0000, 32'h0BADF00D, 0, 3);

        repeat (2) @(posedge clk);
        check("bus queue drained", 32'(bus_q.size()), 32'd0);
        check("resp queue drained", 32'(resp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
